// File: rtl/mult4_pkg.sv
// Shared definitions for the 4x4 multiplier BIST initiator.
package mult4_pkg;

  localparam int N_DEF      = 4;
  localparam int SETTLE_DEF = 4;
  localparam int ERR_W      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } bist_state_t;

endpackage

// File: rtl/mult4_bist_if.sv
// Operand/product bus between the BIST initiator (master) and the multiplier core (slave).
interface mult4_bist_if #(
  parameter int N = 4
);
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] dut_p;

  modport master (output op_a, output op_b, input dut_p);
  modport slave  (input op_a, input op_b, output dut_p);
endinterface

// File: rtl/mult4_bist_shift_add_mult.sv
// Sequential shift-add reference multiplier: one partial product per cycle,
// result valid N cycles after ref_start and held until the next ref_start.
module shift_add_mult #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ref_start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] ref_p_o,
  output logic           ref_valid_o
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_comb begin
    acc_d   = acc_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (ref_start_i) begin
      acc_d   = '0;
      a_sh_d  = {{N{1'b0}}, a_i};
      b_sh_d  = b_i;
      cnt_d   = CW'(N);
      valid_d = 1'b0;
    end else if (cnt_q != '0) begin
      if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) valid_d = 1'b1;
    end
  end

  // Register the datapath; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign ref_p_o     = acc_q;
  assign ref_valid_o = valid_q;

endmodule

// File: rtl/mult4_bist.sv
// BIST initiator for the 4x4 multiplier core: sweeps all operand pairs, compares the
// core product against a shift-add reference and reports pass, error count and first failure.
//
// state | meaning
// IDLE  | waiting for start; status outputs hold last sweep result
// DRIVE | launch operands from the index, kick the reference multiplier
// WAIT  | SETTLE cycles for core and reference to settle (down-counter)
// CMP   | compare dut_p to reference, update errors, advance or finish
// DONE  | one-cycle done pulse, pass valid
//
// SETTLE must be at least N so the reference is valid by CMP.
module mult4_bist
  import mult4_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  mult4_bist_if.master     bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [N-1:0]     fail_a_o,
  output logic [N-1:0]     fail_b_o
);

  localparam int SW = $clog2(SETTLE + 1);

  bist_state_t      state_q, state_d;
  logic [2*N-1:0]   idx_q, idx_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [N-1:0]     op_a_q, op_a_d;
  logic [N-1:0]     op_b_q, op_b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N-1:0]     fail_a_q, fail_a_d;
  logic [N-1:0]     fail_b_q, fail_b_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             ref_start;
  logic             mismatch;
  logic [2*N-1:0]   ref_p;
  logic             ref_valid;

  shift_add_mult #(.N(N)) u_ref (
    .clk         (clk),
    .rst         (rst),
    .ref_start_i (ref_start),
    .a_i         (idx_q[2*N-1:N]),
    .b_i         (idx_q[N-1:0]),
    .ref_p_o     (ref_p),
    .ref_valid_o (ref_valid)
  );

  // Next-state and result update for the sweep sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    err_d     = err_q;
    fail_a_d  = fail_a_q;
    fail_b_d  = fail_b_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    ref_start = 1'b0;
    mismatch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = DRIVE;
          idx_d    = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      DRIVE: begin
        op_a_d    = idx_q[2*N-1:N];
        op_b_d    = idx_q[N-1:0];
        ref_start = 1'b1;
        settle_d  = SW'(SETTLE - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (settle_q == '0) state_d = CMP;
        else                settle_d = settle_q - 1'b1;
      end
      CMP: begin
        mismatch = (bus.dut_p != ref_p);
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_a_d = op_a_q;
            fail_b_d = op_b_q;
          end
        end
        if (idx_q == '1) begin
          // pass and busy settle on entry to DONE so both are valid during the done pulse
          state_d = DONE;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; synchronous reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.op_a    = op_a_q;
  assign bus.op_b    = op_b_q;
  assign busy_o      = busy_q;
  assign done_o      = (state_q == DONE);
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_a_o    = fail_a_q;
  assign fail_b_o    = fail_b_q;

  a_ref_ready_in_cmp: assert property (@(posedge clk) disable iff (rst)
    (state_q == CMP) |-> ref_valid);

endmodule
